// File: rtl/radix2_seqdiv_pkg.sv
// Shared definitions for the radix-2 sequential divider: FSM encoding and
// the operand-width / steps-per-clock legality rule.
package radix2_seqdiv_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Width must be even and >= 4; steps per clock must tile the width exactly.
  function automatic bit widthStepsLegal(input int width, input int steps);
    return (width >= 4) && (width % 2 == 0) && (steps >= 1) && (width % steps == 0);
  endfunction

endpackage

// File: rtl/radix2_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference when it fits.
module radix2_step
  import radix2_seqdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic             dividendBit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic             qBit
);

  // Shifted value needs one extra bit; the kept remainder is always < divisor.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtract and select.
  always_comb begin
    shifted = {remIn, dividendBit};
    diff    = shifted - {1'b0, divisor};
    qBit    = (shifted >= {1'b0, divisor});
    remOut  = qBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/radix2_seqdiv.sv
// Sequential signed/unsigned divider, STEPS radix-2 steps per clock.
// Magnitudes are divided; signs are restored in a single FIX cycle.
module radix2_seqdiv
  import radix2_seqdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 2
) (
  input  logic             iCLOCK,
  input  logic             inRESET,
  input  logic             iRESET_SYNC,
  input  logic             iREQ,
  input  logic             iSIGNED,
  input  logic [WIDTH-1:0] iDIVIDEND,
  input  logic [WIDTH-1:0] iDIVISOR,
  output logic             oBUSY,
  output logic             oVALID,
  output logic [WIDTH-1:0] oQUOTIENT,
  output logic [WIDTH-1:0] oREMAINDER,
  output logic             oDIVZERO
);

  localparam int N  = WIDTH / STEPS;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!widthStepsLegal(WIDTH, STEPS)) begin : gIllegal
    $error("radix2_seqdiv: WIDTH must be even, >= 4, and divisible by STEPS");
  end

  logic [1:0]       state, stateNext;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dq;        // dividend bits shift out MSB-first, quotient bits shift in
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvsr;
  logic             negQ, negR;
  logic             accept, calcEn, fixEn;
  logic [WIDTH-1:0] absDividend, absDivisor;
  logic             dvdNeg, dvsNeg;

  logic [STEPS:0][WIDTH-1:0] remChain;
  logic [STEPS-1:0]          qVec;

  assign remChain[0] = rem;

  // Step i consumes dividend bit WIDTH-1-i; its quotient bit lands MSB-first in qVec.
  for (genvar i = 0; i < STEPS; i++) begin : gStep
    radix2_step #(.WIDTH(WIDTH)) uStep (
      .remIn      (remChain[i]),
      .dividendBit(dq[WIDTH-1-i]),
      .divisor    (dvsr),
      .remOut     (remChain[i+1]),
      .qBit       (qVec[STEPS-1-i])
    );
  end

  // Operand magnitudes and sign flags for the accept cycle.
  always_comb begin
    dvdNeg      = iSIGNED & iDIVIDEND[WIDTH-1];
    dvsNeg      = iSIGNED & iDIVISOR[WIDTH-1];
    absDividend = dvdNeg ? -iDIVIDEND : iDIVIDEND;
    absDivisor  = dvsNeg ? -iDIVISOR  : iDIVISOR;
  end

  // FSM state register.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) state <= ST_IDLE;
    else          state <= stateNext;
  end

  // FSM next state; synchronous clear overrides every transition.
  always_comb begin
    stateNext = state;
    if (iRESET_SYNC) stateNext = ST_IDLE;
    else begin
      case (state)
        ST_IDLE: if (iREQ) stateNext = ST_CALC;
        ST_CALC: if (cnt == LAST) stateNext = ST_FIX;
        ST_FIX:  stateNext = ST_IDLE;
        default: stateNext = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: busy flag and datapath enables.
  always_comb begin
    oBUSY  = (state != ST_IDLE);
    accept = (state == ST_IDLE) & iREQ;
    calcEn = (state == ST_CALC);
    fixEn  = (state == ST_FIX);
  end

  // Datapath and result registers. A zero divisor runs the full schedule:
  // every step subtracts zero, leaving all-ones quotient and |dividend| as
  // remainder; the remainder sign fix then restores the original dividend.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      cnt <= '0; dq <= '0; rem <= '0; dvsr <= '0; negQ <= 1'b0; negR <= 1'b0;
      oVALID <= 1'b0; oQUOTIENT <= '0; oREMAINDER <= '0; oDIVZERO <= 1'b0;
    end else if (iRESET_SYNC) begin
      cnt <= '0; dq <= '0; rem <= '0; dvsr <= '0; negQ <= 1'b0; negR <= 1'b0;
      oVALID <= 1'b0; oQUOTIENT <= '0; oREMAINDER <= '0; oDIVZERO <= 1'b0;
    end else begin
      oVALID <= 1'b0;
      if (accept) begin
        dq   <= absDividend;
        rem  <= '0;
        dvsr <= absDivisor;
        negQ <= dvdNeg ^ dvsNeg;
        negR <= dvdNeg;
        cnt  <= '0;
      end
      if (calcEn) begin
        dq  <= (dq << STEPS) | WIDTH'(qVec);
        rem <= remChain[STEPS];
        cnt <= cnt + 1'b1;
      end
      if (fixEn) begin
        oQUOTIENT  <= (dvsr == '0) ? '1 : (negQ ? -dq : dq);
        oREMAINDER <= negR ? -rem : rem;
        oDIVZERO   <= (dvsr == '0);
        oVALID     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_radix2_seqdiv.sv
// Directed bench for radix2_seqdiv: behavioural result/latency model with a
// per-cycle compare, plus hand-computed literal expectations.
module tb_radix2_seqdiv;

  localparam int W   = 32;
  localparam int LAT = W / 2 + 1;

  logic clk = 1'b0, rstN = 1'b0, rstSync = 1'b0, req = 1'b0, sgn = 1'b0;
  logic [W-1:0] dvd = '0, dvs = '0;
  logic busy, vld, dz;
  logic [W-1:0] q, r;

  logic req16 = 1'b0, sgn16 = 1'b0;
  logic [15:0] dvd16 = '0, dvs16 = '0;
  logic busy16, vld16, dz16;
  logic [15:0] q16, r16;

  int checks = 0, errors = 0, cyc = 0;
  bit started = 1'b0;

  radix2_seqdiv #(.WIDTH(W), .STEPS(2)) dut (
    .iCLOCK(clk), .inRESET(rstN), .iRESET_SYNC(rstSync), .iREQ(req), .iSIGNED(sgn),
    .iDIVIDEND(dvd), .iDIVISOR(dvs), .oBUSY(busy), .oVALID(vld),
    .oQUOTIENT(q), .oREMAINDER(r), .oDIVZERO(dz)
  );

  radix2_seqdiv #(.WIDTH(16), .STEPS(4)) dut16 (
    .iCLOCK(clk), .inRESET(rstN), .iRESET_SYNC(rstSync), .iREQ(req16), .iSIGNED(sgn16),
    .iDIVIDEND(dvd16), .iDIVISOR(dvs16), .oBUSY(busy16), .oVALID(vld16),
    .oQUOTIENT(q16), .oREMAINDER(r16), .oDIVZERO(dz16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference division with plain integer arithmetic: {divzero, quotient, remainder}.
  function automatic logic [64:0] divModel(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, qq, rr;
    if (b == 32'h0) return {1'b1, 32'hFFFFFFFF, a};
    if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    qq = sa / sb;
    rr = sa % sb;
    return {1'b0, qq[31:0], rr[31:0]};
  endfunction

  // Transaction-level model: one request at a time, result LAT edges after acceptance.
  logic mBusy = 1'b0, mValid = 1'b0, mDz = 1'b0;
  logic [W-1:0] mQ = '0, mR = '0;
  logic [64:0] mPend = '0;
  int mLeft = 0;

  always @(posedge clk or negedge rstN) begin
    if (!rstN || rstSync) begin
      mBusy = 1'b0; mValid = 1'b0; mLeft = 0; mQ = '0; mR = '0; mDz = 1'b0;
    end else begin
      mValid = 1'b0;
      if (mBusy) begin
        mLeft--;
        if (mLeft == 0) begin
          mBusy = 1'b0; mValid = 1'b1;
          {mDz, mQ, mR} = mPend;
        end
      end else if (req) begin
        mBusy = 1'b1; mLeft = LAT;
        mPend = divModel(sgn, dvd, dvs);
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("m_busy", busy, mBusy);
      chk("m_valid", vld, mValid);
      chk("m_quot", q, mQ);
      chk("m_rem", r, mR);
      chk("m_dz", dz, mDz);
    end
  end

  task automatic waitValid(input int expCyc, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!vld && n < 60);
    chk({name, "_latency"}, cyc, expCyc);
  endtask

  task automatic runOne(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz);
    int e0;
    @(posedge clk); #1; req = 1'b1; sgn = s; dvd = a; dvs = b;
    @(posedge clk); #1; e0 = cyc; req = 1'b0;
    waitValid(e0 + LAT, name);
    chk({name, "_q"}, q, eq);
    chk({name, "_r"}, r, er);
    chk({name, "_dz"}, dz, edz);
    @(negedge clk);
    chk({name, "_pulse"}, vld, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, n;
    bit saw;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", vld, 1'b0);
    chk("rst_q", q, 32'h0);
    chk("rst_r", r, 32'h0);
    chk("rst_dz", dz, 1'b0);
    rstN = 1'b1;
    started = 1'b1;

    runOne("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    runOne("sm100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    runOne("s100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0);
    runOne("smin_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0);
    runOne("u5_0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1);
    runOne("s5_0", 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1);
    runOne("u_big", 1'b0, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF, 1'b0);

    // Request held high: ignored while busy, re-accepted in the valid cycle.
    @(posedge clk); #1; req = 1'b1; sgn = 1'b0; dvd = 32'd1000; dvs = 32'd3;
    @(posedge clk); #1; e0 = cyc;
    waitValid(e0 + LAT, "held1");
    chk("held1_q", q, 32'd333);
    chk("held1_r", r, 32'd1);
    dvd = 32'd77; dvs = 32'd5;
    waitValid(e0 + 2 * LAT + 1, "b2b");
    chk("b2b_q", q, 32'd15);
    chk("b2b_r", r, 32'd2);
    req = 1'b0;
    @(negedge clk);

    // Synchronous clear during CALC cycle 5.
    @(posedge clk); #1; req = 1'b1; dvd = 32'd12345; dvs = 32'd7;
    @(posedge clk); #1; req = 1'b0;
    repeat (5) @(posedge clk);
    #1; rstSync = 1'b1;
    @(posedge clk); #1; rstSync = 1'b0;
    @(negedge clk);
    chk("srst_busy", busy, 1'b0);
    chk("srst_q", q, 32'h0);
    chk("srst_r", r, 32'h0);
    saw = 1'b0;
    repeat (25) begin @(negedge clk); if (vld) saw = 1'b1; end
    chk("srst_novalid", saw, 1'b0);
    runOne("after_srst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    // Asynchronous reset pulse during CALC.
    @(posedge clk); #1; req = 1'b1; dvd = 32'd999; dvs = 32'd10;
    @(posedge clk); #1; req = 1'b0;
    repeat (5) @(posedge clk);
    #1; rstN = 1'b0; #2; rstN = 1'b1;
    @(negedge clk);
    chk("arst_busy", busy, 1'b0);
    chk("arst_q", q, 32'h0);
    chk("arst_r", r, 32'h0);
    saw = 1'b0;
    repeat (25) begin @(negedge clk); if (vld) saw = 1'b1; end
    chk("arst_novalid", saw, 1'b0);
    runOne("after_arst", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);

    // Second parameter set: 16 bits, 4 steps per clock.
    @(posedge clk); #1; req16 = 1'b1; dvd16 = 16'hFFFF; dvs16 = 16'h0003;
    @(posedge clk); #1; e0 = cyc; req16 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!vld16 && n < 30);
    chk("w16_latency", cyc, e0 + 5);
    chk("w16_q", q16, 16'h5555);
    chk("w16_r", r16, 16'h0000);
    chk("w16_dz", dz16, 1'b0);
    @(negedge clk);
    chk("w16_pulse", vld16, 1'b0);

    started = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
